// File: rtl/vedic8x8_seq.sv
// Sequential 8x8 unsigned multiplier built on a single time-shared 4x4 Vedic core.
// Latency 4 cycles (5 with PIPE_PP=1) from accept to out_valid; result held until out_ready.

module vedic4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [8:0] s
);
  // Urdhva-tiryagbhyam 2x2 block: vertical and crosswise products
  function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
    logic c;
    logic [3:0] q;
    q[0] = x[0] & y[0];
    q[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c    = (x[1] & y[0]) & (x[0] & y[1]);
    q[2] = (x[1] & y[1]) ^ c;
    q[3] = (x[1] & y[1]) & c;
    return q;
  endfunction

  logic [3:0] q0, q1, q2, q3;
  logic [4:0] mid;

  assign q0  = v2(a[1:0], b[1:0]);
  assign q1  = v2(a[3:2], b[1:0]);
  assign q2  = v2(a[1:0], b[3:2]);
  assign q3  = v2(a[3:2], b[3:2]);
  assign mid = {1'b0, q1} + {1'b0, q2};
  assign s   = {1'b0, q3, q0} + {2'b00, mid, 2'b00};
endmodule

module vedic8x8_seq #(
  parameter bit PIPE_PP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state, step;
  logic [7:0]  ra, rb;
  logic [15:0] acc, term;
  logic [3:0]  ca, cb;
  logic [8:0]  cs;
  logic        unused_s8;
  logic        issue_en, acc_vld;
  logic [1:0]  acc_tag;
  logic [7:0]  acc_pp;

  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign unused_s8 = cs[8];

  // step[0] selects the high nibble of ra, step[1] the high nibble of rb
  always_comb begin
    ca = step[0] ? ra[7:4] : ra[3:0];
    cb = step[1] ? rb[7:4] : rb[3:0];
  end

  vedic4x4 u_core (.a(ca), .b(cb), .s(cs));

  generate
    if (PIPE_PP) begin : g_pipe
      logic       issued;
      logic       pp_vld;
      logic [1:0] pp_tag;
      logic [7:0] pp_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          issued <= 1'b0;
          pp_vld <= 1'b0;
          pp_tag <= 2'd0;
          pp_q   <= 8'h00;
        end else begin
          if (state == IDLE)
            issued <= 1'b0;
          else if (issue_en && step == 2'd3)
            issued <= 1'b1;
          pp_vld <= issue_en;
          pp_tag <= step;
          pp_q   <= cs[7:0];
        end
      end

      assign issue_en = (state == MUL) && !issued;
      assign acc_vld  = pp_vld;
      assign acc_tag  = pp_tag;
      assign acc_pp   = pp_q;
    end else begin : g_comb
      assign issue_en = (state == MUL);
      assign acc_vld  = (state == MUL);
      assign acc_tag  = step;
      assign acc_pp   = cs[7:0];
    end
  endgenerate

  always_comb begin
    case (acc_tag)
      2'd0:    term = {8'h00, acc_pp};
      2'd3:    term = {acc_pp, 8'h00};
      default: term = {4'h0, acc_pp, 4'h0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= 2'd0;
      acc       <= 16'h0000;
      ra        <= 8'h00;
      rb        <= 8'h00;
      p         <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      if (issue_en)
        step <= step + 2'd1;
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra    <= a;
            rb    <= b;
            acc   <= 16'h0000;
            step  <= 2'd0;
            state <= MUL;
          end
        end
        MUL: begin
          if (acc_vld) begin
            if (acc_tag == 2'd3) begin
              p         <= acc + term;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              acc <= acc + term;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
